// File: rtl/dlsc_pcie_s6_trn_tx.sv
// Spartan-6 PCIe TRN transmit driver: arbitrates two TLP source FIFOs onto
// the core's 32-bit TX interface through a single registered output stage.
module dlsc_pcie_s6_trn_tx #(
    parameter int CPL_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst,

    output logic        in0_ready,
    input  logic        in0_valid,
    input  logic        in0_last,
    input  logic [31:0] in0_data,

    output logic        in1_ready,
    input  logic        in1_valid,
    input  logic        in1_last,
    input  logic [31:0] in1_data,

    output logic [31:0] trn_td,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [5:0]  trn_tbuf_av,
    input  logic        trn_terr_drop_n,
    input  logic        trn_tcfg_req_n,
    output logic        trn_tcfg_gnt_n,

    output logic        err_drop
);

    typedef enum logic [1:0] {
        IDLE,
        ACT0,
        ACT1
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        sof_pending;

    logic        out_free;
    logic        elig0;
    logic        elig1;
    logic        pick0;
    logic        pick1;
    logic        acc;
    logic        acc_last;
    logic [31:0] acc_data;
    logic        unused_tbuf;

    assign unused_tbuf    = ^trn_tbuf_av[5:3];
    assign trn_tsrc_dsc_n = 1'b1;

    assign out_free  = trn_tsrc_rdy_n | ~trn_tdst_rdy_n;
    assign in0_ready = (state == ACT0) & out_free;
    assign in1_ready = (state == ACT1) & out_free;

    // port 1 carries requests: posted writes vs non-posted reads use different credits
    assign elig0 = in0_valid & trn_tbuf_av[2];
    assign elig1 = in1_valid & (in1_data[30] ? trn_tbuf_av[1] : trn_tbuf_av[0]);

    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (CPL_PRIORITY != 0) begin
            pick0 = elig0;
        end else begin
            pick0 = elig0 & (last_grant | ~elig1);
        end
        pick1 = elig1 & ~pick0;
    end

    assign acc      = (in0_ready & in0_valid) | (in1_ready & in1_valid);
    assign acc_last = (state == ACT1) ? in1_last : in0_last;
    assign acc_data = (state == ACT1) ? in1_data : in0_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            sof_pending    <= 1'b0;
            trn_td         <= '0;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            trn_tcfg_gnt_n <= 1'b1;
            err_drop       <= 1'b0;
        end else begin
            err_drop <= ~trn_terr_drop_n;

            if (out_free) begin
                if (acc) begin
                    trn_td         <= acc_data;
                    trn_tsof_n     <= ~sof_pending;
                    trn_teof_n     <= ~acc_last;
                    trn_tsrc_rdy_n <= 1'b0;
                end else begin
                    trn_tsof_n     <= 1'b1;
                    trn_teof_n     <= 1'b1;
                    trn_tsrc_rdy_n <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    // grant only once the last word has fully drained
                    trn_tcfg_gnt_n <= ~(~trn_tcfg_req_n & trn_tsrc_rdy_n);
                    if (trn_tcfg_req_n) begin
                        if (pick0) begin
                            state       <= ACT0;
                            sof_pending <= 1'b1;
                        end else if (pick1) begin
                            state       <= ACT1;
                            sof_pending <= 1'b1;
                        end
                    end
                end
                ACT0, ACT1: begin
                    trn_tcfg_gnt_n <= 1'b1;
                    if (acc) begin
                        sof_pending <= 1'b0;
                        if (acc_last) begin
                            state      <= IDLE;
                            last_grant <= (state == ACT1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_trn_tx.sv
// Scoreboard bench for dlsc_pcie_s6_trn_tx: directed TLPs, expected TRN words
// queued up front and checked by an independent output monitor.
module tb_dlsc_pcie_s6_trn_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in0_ready, in0_valid, in0_last;
    logic [31:0] in0_data;
    logic        in1_ready, in1_valid, in1_last;
    logic [31:0] in1_data;
    logic [31:0] trn_td;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;
    logic        trn_terr_drop_n, trn_tcfg_req_n, trn_tcfg_gnt_n, err_drop;

    dlsc_pcie_s6_trn_tx #(.CPL_PRIORITY(0)) dut (
        .clk(clk), .rst(rst),
        .in0_ready(in0_ready), .in0_valid(in0_valid),
        .in0_last(in0_last), .in0_data(in0_data),
        .in1_ready(in1_ready), .in1_valid(in1_valid),
        .in1_last(in1_last), .in1_data(in1_data),
        .trn_td(trn_td), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
        .trn_terr_drop_n(trn_terr_drop_n), .trn_tcfg_req_n(trn_tcfg_req_n),
        .trn_tcfg_gnt_n(trn_tcfg_gnt_n), .err_drop(err_drop)
    );

    typedef struct packed { logic [31:0] d; logic l; } iw_t;
    typedef struct packed { logic [31:0] d; logic sof_n; logic eof_n; } ow_t;

    iw_t q0[$];
    iw_t q1[$];
    ow_t exp_q[$];
    int  pop_cyc[$];
    int  checks = 0;
    int  passes = 0;
    int  cyc = 0;
    bit  rand_tdst = 1'b0;
    bit  cfg_done = 1'b0;
    int  sof_bad = 0;
    int  gnt_bad = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input int p, input logic [31:0] d, input logic l);
        iw_t w;
        w.d = d;
        w.l = l;
        if (p == 0) q0.push_back(w);
        else q1.push_back(w);
    endtask

    task automatic expw(input logic [31:0] d, input logic sof, input logic eof);
        ow_t w;
        w.d = d;
        w.sof_n = ~sof;
        w.eof_n = ~eof;
        exp_q.push_back(w);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && k < 400) begin
            @(posedge clk);
            k++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        repeat (3) sync();
    endtask

    task automatic reset_vals(input string name);
        chk({name, "_td"}, trn_td, 0);
        chk({name, "_sof_n"}, trn_tsof_n, 1);
        chk({name, "_eof_n"}, trn_teof_n, 1);
        chk({name, "_src_rdy_n"}, trn_tsrc_rdy_n, 1);
        chk({name, "_dsc_n"}, trn_tsrc_dsc_n, 1);
        chk({name, "_gnt_n"}, trn_tcfg_gnt_n, 1);
        chk({name, "_in0_ready"}, in0_ready, 0);
        chk({name, "_in1_ready"}, in1_ready, 0);
        chk({name, "_err_drop"}, err_drop, 0);
    endtask

    // Input drivers: acceptance is judged at the negedge before the accepting edge
    initial begin : drv0
        logic acc;
        in0_valid = 1'b0; in0_last = 1'b0; in0_data = '0;
        forever begin
            @(negedge clk);
            acc = in0_valid && in0_ready;
            @(posedge clk);
            #1;
            if (acc && !rst && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                in0_valid = 1'b1; in0_data = q0[0].d; in0_last = q0[0].l;
            end else begin
                in0_valid = 1'b0; in0_last = 1'b0;
            end
        end
    end

    initial begin : drv1
        logic acc;
        in1_valid = 1'b0; in1_last = 1'b0; in1_data = '0;
        forever begin
            @(negedge clk);
            acc = in1_valid && in1_ready;
            @(posedge clk);
            #1;
            if (acc && !rst && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                in1_valid = 1'b1; in1_data = q1[0].d; in1_last = q1[0].l;
            end else begin
                in1_valid = 1'b0; in1_last = 1'b0;
            end
        end
    end

    initial begin : dst
        trn_tdst_rdy_n = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            trn_tdst_rdy_n = rand_tdst ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin : mon
        ow_t a, e, held;
        bit  held_v;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            a.d = trn_td; a.sof_n = trn_tsof_n; a.eof_n = trn_teof_n;
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("stall_hold", {trn_tsrc_rdy_n, a}, {1'b0, held});
                    held_v = 1'b0;
                end
                if (!trn_tsrc_rdy_n && trn_tdst_rdy_n) begin
                    held = a;
                    held_v = 1'b1;
                end
                if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_word: got %0h expected none", a);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_word", a, e);
                        pop_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin : main
        int k;
        trn_tbuf_av = 6'h3F;
        trn_terr_drop_n = 1'b1;
        trn_tcfg_req_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_vals("rst_init");
        sync();
        rst = 1'b0;
        sync();

        // round-robin, port 0 wins first tie after reset
        pop_cyc.delete();
        put(0, 32'h0000_0010, 1'b1); put(1, 32'h0000_0020, 1'b1);
        put(0, 32'h0000_0011, 1'b1); put(1, 32'h0000_0021, 1'b1);
        expw(32'h0000_0010, 1, 1); expw(32'h0000_0020, 1, 1);
        expw(32'h0000_0011, 1, 1); expw(32'h0000_0021, 1, 1);
        drain("rr");
        chk("rr_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("rr_gap", pop_cyc[i] - pop_cyc[i-1], 2);
        end

        // 3-word TLP on port 0, latency and back-to-back words
        pop_cyc.delete();
        put(0, 32'hA000_0001, 1'b0); put(0, 32'h1, 1'b0); put(0, 32'h2, 1'b1);
        expw(32'hA000_0001, 1, 0); expw(32'h1, 0, 0); expw(32'h2, 0, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in0_valid && k < 20);
        chk("t1_valid_seen", in0_valid, 1);
        chk("t1_out_idle", trn_tsrc_rdy_n, 1);
        @(negedge clk);
        chk("t1_ready", in0_ready, 1);
        chk("t1_out_idle2", trn_tsrc_rdy_n, 1);
        @(negedge clk);
        chk("t1_first_word", {trn_tsrc_rdy_n, trn_tsof_n}, 2'b00);
        drain("t1");
        chk("t1_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            chk("t1_consec_a", pop_cyc[1] - pop_cyc[0], 1);
            chk("t1_consec_b", pop_cyc[2] - pop_cyc[1], 1);
        end

        // non-posted credit missing: port 0 served until credit returns
        trn_tbuf_av = 6'h3E;
        put(1, 32'h0000_0001, 1'b1);
        put(0, 32'h30, 1'b1); put(0, 32'h31, 1'b1); put(0, 32'h32, 1'b1);
        expw(32'h30, 1, 1); expw(32'h31, 1, 1); expw(32'h32, 1, 1);
        expw(32'h0000_0001, 1, 1);
        k = 0;
        while (q0.size() != 0 && k < 60) begin
            sync();
            k++;
        end
        chk("np_p1_waiting", q1.size(), 1);
        trn_tbuf_av = 6'h3F;
        @(negedge clk);
        chk("np_not_yet", in1_ready, 0);
        @(negedge clk);
        chk("np_start", in1_ready, 1);
        drain("np");

        // 10-word TLP with random destination stalls
        for (int i = 0; i < 10; i++) begin
            put(0, 32'h0000_0500 + i, (i == 9));
            expw(32'h0000_0500 + i, (i == 0), (i == 9));
        end
        rand_tdst = 1'b1;
        drain("stall");
        rand_tdst = 1'b0;
        repeat (2) sync();

        // config request arriving mid-TLP
        for (int i = 0; i < 4; i++) begin
            put(0, 32'h60 + i, (i == 3));
            expw(32'h60 + i, (i == 0), (i == 3));
        end
        expw(32'h4000_0077, 1, 1);
        cfg_done = 1'b0;
        fork
            begin
                repeat (4) sync();
                trn_tcfg_req_n = 1'b0;
                put(1, 32'h4000_0077, 1'b1);
                k = 0;
                while (trn_tcfg_gnt_n && k < 40) begin
                    sync();
                    k++;
                end
                chk("cfg_gnt", trn_tcfg_gnt_n, 0);
                chk("cfg_p0_done", exp_q.size(), 1);
                repeat (3) sync();
                chk("cfg_p1_held", q1.size(), 1);
                trn_tcfg_req_n = 1'b1;
                @(negedge clk);
                chk("cfg_gnt_hold", trn_tcfg_gnt_n, 0);
                @(negedge clk);
                chk("cfg_gnt_release", trn_tcfg_gnt_n, 1);
                cfg_done = 1'b1;
            end
            begin
                while (!cfg_done) begin
                    @(negedge clk);
                    if (!trn_tcfg_req_n && !trn_tsrc_rdy_n && !trn_tsof_n) sof_bad++;
                    if (!trn_tcfg_gnt_n && (!trn_tsrc_rdy_n || in0_ready || in1_ready)) gnt_bad++;
                end
            end
        join
        chk("cfg_no_sof", sof_bad, 0);
        chk("cfg_gnt_idle_only", gnt_bad, 0);
        drain("cfg");

        // error drop pulse
        sync();
        trn_terr_drop_n = 1'b0;
        @(negedge clk);
        chk("err_before", err_drop, 0);
        sync();
        trn_terr_drop_n = 1'b1;
        @(negedge clk);
        chk("err_pulse", err_drop, 1);
        @(negedge clk);
        chk("err_clear", err_drop, 0);

        // reset in the middle of a 4-word TLP
        for (int i = 0; i < 4; i++) begin
            put(0, 32'h70 + i, (i == 3));
            expw(32'h70 + i, (i == 0), (i == 3));
        end
        k = 0;
        while (exp_q.size() > 2 && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        reset_vals("rst_mid");
        chk("rst_partial", exp_q.size(), 2);
        exp_q.delete();
        q0.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        sync();
        put(0, 32'h80, 1'b0); put(0, 32'h81, 1'b1);
        expw(32'h80, 1, 0); expw(32'h81, 0, 1);
        drain("post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dlsc_pcie_s6_trn_tx.md
# dlsc_pcie_s6_trn_tx

Transmit-side TRN driver for the Spartan-6 PCIe endpoint. Consumes TLPs from two per-source cut-through transmit FIFOs (port 0 = completions, port 1 = requests), arbitrates between them at TLP boundaries, and checks `trn_tbuf_av` before each TLP. Drives the core's 32-bit TRN TX interface through a single registered output stage. It also services the core's configuration-transmit request (`trn_tcfg_req_n`/`trn_tcfg_gnt_n`).

## Interface
- `CPL_PRIORITY`, 0: 0 = round-robin between ports; 1 = port 0 always wins when eligible.
- `clk` in 1: single clock (core `trn_clk`).
- `rst` in 1: asynchronous, active-high reset.
- `in0_ready` out 1: port 0 word accepted when `in0_ready && in0_valid`.
- `in0_valid` in 1: port 0 word valid.
- `in0_last` in 1: last word of TLP on port 0.
- `in0_data` in 32: port 0 TLP word.
- `in1_ready`, `in1_valid`, `in1_last`, `in1_data` (out 1, in 1, in 1, in 32): same as port 0, for port 1.
- `trn_td` out 32: TX data.
- `trn_tsof_n` out 1: start of frame, active-low.
- `trn_teof_n` out 1: end of frame, active-low.
- `trn_tsrc_rdy_n` out 1: source ready, active-low.
- `trn_tsrc_dsc_n` out 1: discontinue; constant 1.
- `trn_tdst_rdy_n` in 1: destination ready, active-low.
- `trn_tbuf_av` in 6: core buffer availability. Bit 0 = non-posted, bit 1 = posted, bit 2 = completion.
- `trn_terr_drop_n` in 1: core dropped a TLP, active-low.
- `trn_tcfg_req_n` in 1: core requests TX slot for a config TLP, active-low.
- `trn_tcfg_gnt_n` out 1: grant to core, active-low.
- `err_drop` out 1: one-cycle pulse, registered copy of `!trn_terr_drop_n`.

## Operation
- Output register holds one word: `trn_td`, SOF, EOF and `src_rdy`.
  - Register is free when `trn_tsrc_rdy_n==1` or `trn_tdst_rdy_n==0`.
  - Let `out_free` denote this condition.
- States are IDLE, ACT0 and ACT1. Reset enters IDLE with `last_grant=1`, so port 0 wins the first tie.
- Eligibility in IDLE:
  - Port 0 is eligible when `in0_valid && trn_tbuf_av[2]`.
  - Port 1 is eligible when `in1_valid` and the class bit is set. The class bit is `trn_tbuf_av[1]` if `in1_data[30]` (fmt has data, posted) else `trn_tbuf_av[0]`.
- IDLE, config request: if `trn_tcfg_req_n==0` and `trn_tsrc_rdy_n==1` (output idle), register `trn_tcfg_gnt_n<=0`.
  - No TLP starts while `trn_tcfg_req_n==0`.
  - `trn_tcfg_gnt_n` returns to 1 the cycle after `trn_tcfg_req_n` deasserts.
  - Outside IDLE, `trn_tcfg_gnt_n` is 1.
- IDLE, no config request: choose among eligible ports.
  - Round-robin: the port other than `last_grant` wins if eligible.
  - `CPL_PRIORITY=1`: port 0 wins if eligible.
  - Go to ACTx. Set `sof_pending=1`.
- ACTx:
  - `inx_ready = out_free`; the other port's ready is 0.
  - Each accepted word loads the output register with SOF = `sof_pending` and EOF = `inx_last`, then clears `sof_pending`.
  - Accepting a word with `last=1` returns to IDLE and sets `last_grant=x`.
- `trn_tbuf_av` is sampled only at TLP start. Mid-TLP drops in `trn_tbuf_av` are ignored; the core's `trn_tdst_rdy_n` provides the stall.
- A 1-word TLP (last on first word) asserts SOF and EOF together.
- An input `valid` drop mid-TLP leaves the output with `src_rdy` deasserted for that cycle. No SOF is repeated. The upstream FIFO's first-word holdoff makes this rare.
- Reset values: `trn_td=0`, `trn_tsof_n=1`, `trn_teof_n=1`, `trn_tsrc_rdy_n=1`, `trn_tsrc_dsc_n=1`, `trn_tcfg_gnt_n=1`, `in0_ready=0`, `in1_ready=0`, `err_drop=0`.
- Reset asserted mid-TLP: all of the above apply immediately. The partial TLP is abandoned; no EOF is sent.

## Timing
- Cycle t: IDLE with an eligible port and no config request. Cycle t+1: ACTx, `inx_ready=out_free`. Cycle t+2: first word on TRN.
- Gap of exactly one IDLE cycle between the EOF-word acceptance and the next TLP's first input acceptance.
- Throughput is 1 word/cycle within a TLP while `trn_tdst_rdy_n==0`.
- `inx_ready` depends combinationally on `trn_tdst_rdy_n`; it is the only comb path.
- While `trn_tdst_rdy_n==1` with the output valid, `trn_td` and all flags hold stable.
- Config grant: `trn_tcfg_gnt_n` falls 1 cycle after `trn_tcfg_req_n` falls (when idle). A TLP in progress delays the grant until return to IDLE.
- `err_drop` is 1 cycle after `trn_terr_drop_n` is low, for each low cycle.

## Test plan
- Port 0 sends a 3-word TLP (0xA0000001, 0x1, 0x2); `tbuf_av=6'h3F`, `tdst_rdy_n=0`:
  - TRN shows the 3 words on consecutive cycles.
  - SOF is on word 0 and EOF on word 2.
  - First word appears 2 cycles after valid in IDLE.
- Both ports hold back-to-back 1-word TLPs, round-robin: output alternates 0,1,0,1. Each TLP has SOF=EOF=0 (active). One idle cycle separates TLPs.
- Port 1 word0 = 0x00000001 (read, NP) with `tbuf_av[0]=0`, while port 0 is valid with `tbuf_av[2]=1`:
  - Port 0 is served repeatedly.
  - Port 1 starts on the cycle after `tbuf_av[0]` goes to 1.
- `trn_tdst_rdy_n` toggles randomly during a 10-word TLP: every word is delivered exactly once, in order, and held stable while stalled.
- `trn_tcfg_req_n` falls mid-TLP:
  - `trn_tcfg_gnt_n` stays 1 until EOF, then goes to 0 one cycle after IDLE.
  - No SOF occurs while req is low.
- Assert `rst` after 2 of 4 words: all outputs go to reset values immediately. After release, a new TLP is sent with SOF.
